// File: rtl/maj_net_pkg.sv
// ----------------------------------------------------------------------------
// maj_net_pkg
//   Shared types and helpers for the programmable MAJ3 network evaluator.
//   - sel_w()      : operand select width for a given input/node count
//   - operand_t    : one node operand, {inv, sel}
//   - node_cfg_t   : one node table entry, {op_c, op_b, op_a}
//   - state_t      : evaluator FSM state
//   - SEL_CONST0   : select code for the constant-0 operand
//   The struct widths follow the default network size (7 inputs, 6 nodes).
// ----------------------------------------------------------------------------
package maj_net_pkg;

    localparam int N_IN_DEF    = 7;
    localparam int N_NODES_DEF = 6;

    // Select codes: 0 = constant, then inputs, then node values.
    function automatic int sel_w(input int n_in, input int n_nodes);
        return $clog2(1 + n_in + n_nodes);
    endfunction

    localparam int SEL_W_DEF = sel_w(N_IN_DEF, N_NODES_DEF);

    localparam logic [SEL_W_DEF-1:0] SEL_CONST0 = '0;

    typedef struct packed {
        logic                 inv;
        logic [SEL_W_DEF-1:0] sel;
    } operand_t;

    typedef struct packed {
        operand_t op_c;
        operand_t op_b;
        operand_t op_a;
    } node_cfg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/maj_net_eval_maj3_cell.sv
// ----------------------------------------------------------------------------
// maj3_cell
//   Combinational majority-of-three with optional per-input complement.
//   Ports:
//     a, b, c              operand values
//     inv_a, inv_b, inv_c  complement request per operand
//     y                    MAJ(a', b', c') = a'b' | a'c' | b'c'
//   Build option MAJ_INV_EN: when defined the inversion inputs complement
//   their operand; when undefined they are ignored and the cell is a plain
//   monotone majority gate.
// ----------------------------------------------------------------------------
module maj3_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic inv_a,
    input  logic inv_b,
    input  logic inv_c,
    output logic y
);

    logic a_eff;
    logic b_eff;
    logic c_eff;

`ifdef MAJ_INV_EN
    assign a_eff = a ^ inv_a;
    assign b_eff = b ^ inv_b;
    assign c_eff = c ^ inv_c;
`else
    // Inversion bits are stored by the table but have no effect here.
    logic unused_inv;
    assign unused_inv = inv_a ^ inv_b ^ inv_c;
    assign a_eff = a;
    assign b_eff = b;
    assign c_eff = c;
`endif

    assign y = (a_eff & b_eff) | (a_eff & c_eff) | (b_eff & c_eff);

endmodule

// File: rtl/maj_net_eval.sv
// ----------------------------------------------------------------------------
// maj_net_eval
//   Sequential evaluator for a runtime-programmed network of MAJ3 nodes.
//   One node is evaluated per clock in table order; the result is offered on
//   a valid/ready output once all nodes are done.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; the producer holds its data stable while valid is high and
//   ready is low. in_ready is high only in IDLE; out_valid is high only in
//   DONE, where out_data is held until out_ready.
//
//   Ports:
//     clk, rst_n   clock (rising edge), asynchronous active-low reset
//     in_valid     input vector valid
//     in_ready     evaluator idle and able to take a vector
//     in_x         input vector, bit i = x_i
//     out_valid    result valid
//     out_ready    result consumer ready
//     out_data     network output
//     cfg_we       config write strobe (honoured only in IDLE)
//     cfg_addr     0..N_NODES-1 = node entry, N_NODES = output select word
//     cfg_data     node entry {op_c, op_b, op_a}, operand = {inv, sel};
//                  for the output word only the low SEL_W+1 bits are used
//     cfg_err      one-cycle pulse when a config write is dropped
//     busy         FSM is not in IDLE
//
//   Build option MAJ_INV_EN: enables operand and output inversion bits.
// ----------------------------------------------------------------------------
module maj_net_eval
    import maj_net_pkg::*;
#(
    parameter  int N_IN    = N_IN_DEF,
    parameter  int N_NODES = N_NODES_DEF,
    localparam int SEL_W   = sel_w(N_IN, N_NODES),
    localparam int OP_W    = SEL_W + 1,
    localparam int ADDR_W  = $clog2(N_NODES + 1),
    localparam int IDX_W   = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_data,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [3*OP_W-1:0] cfg_data,
    output logic              cfg_err,
    output logic              busy
);

    state_t             state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [N_IN-1:0]    x_q,         x_d;
    logic [N_NODES-1:0] val_q,       val_d;
    node_cfg_t          tbl_q [N_NODES];
    node_cfg_t          tbl_d [N_NODES];
    operand_t           out_cfg_q,   out_cfg_d;
    logic               out_valid_q, out_valid_d;
    logic               out_data_q,  out_data_d;
    logic               cfg_err_q,   cfg_err_d;

    // Operand decode. Node values not yet written this pass are still 0
    // (cleared on accept), so forward and self references read 0 for free.
    function automatic logic op_val(input logic [SEL_W-1:0]   sel,
                                    input logic [N_IN-1:0]    x,
                                    input logic [N_NODES-1:0] n);
        logic v;
        v = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SEL_W'(i + 1)) v = x[i];
        end
        for (int j = 0; j < N_NODES; j++) begin
            if (sel == SEL_W'(N_IN + 1 + j)) v = n[j];
        end
        return v;
    endfunction

    node_cfg_t cur_cfg;
    logic      opa_v, opb_v, opc_v;
    logic      node_y;
    logic      out_sel_v;

    assign cur_cfg = tbl_q[idx_q];

    always_comb begin
        opa_v = op_val(cur_cfg.op_a.sel, x_q, val_q);
        opb_v = op_val(cur_cfg.op_b.sel, x_q, val_q);
        opc_v = op_val(cur_cfg.op_c.sel, x_q, val_q);
    end

    maj3_cell u_cell (
        .a     (opa_v),
        .b     (opb_v),
        .c     (opc_v),
        .inv_a (cur_cfg.op_a.inv),
        .inv_b (cur_cfg.op_b.inv),
        .inv_c (cur_cfg.op_c.inv),
        .y     (node_y)
    );

`ifndef MAJ_INV_EN
    logic unused_out_inv;
    assign unused_out_inv = out_cfg_q.inv;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        val_d       = val_q;
        tbl_d       = tbl_q;
        out_cfg_d   = out_cfg_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cfg_err_d   = 1'b0;
        out_sel_v   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    val_d   = '0;
                    idx_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                val_d[idx_q] = node_y;
                if (idx_q == IDX_W'(N_NODES - 1)) begin
                    // The output may select the node written on this same
                    // edge, so decode from the next-state node values.
                    out_sel_v = op_val(out_cfg_q.sel, x_q, val_d);
`ifdef MAJ_INV_EN
                    out_data_d = out_sel_v ^ out_cfg_q.inv;
`else
                    out_data_d = out_sel_v;
`endif
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A write on the accepting edge lands before the first node is
        // evaluated, so that vector already sees the new table.
        if (cfg_we) begin
            if (state_q != IDLE || cfg_addr > ADDR_W'(N_NODES)) begin
                cfg_err_d = 1'b1;
            end else if (cfg_addr == ADDR_W'(N_NODES)) begin
                out_cfg_d = operand_t'(cfg_data[OP_W-1:0]);
            end else begin
                for (int i = 0; i < N_NODES; i++) begin
                    if (cfg_addr == ADDR_W'(i)) tbl_d[i] = node_cfg_t'(cfg_data);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            val_q       <= '0;
            for (int i = 0; i < N_NODES; i++) tbl_q[i] <= '0;
            out_cfg_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            val_q       <= val_d;
            tbl_q       <= tbl_d;
            out_cfg_q   <= out_cfg_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_maj_net_eval.sv
// ----------------------------------------------------------------------------
// tb_maj_net_eval
//   Directed bench for maj_net_eval at N_IN=7, N_NODES=6 (SEL_W=4, operand
//   width 5, cfg_data 15 bits). Inputs change on the falling edge and
//   outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_maj_net_eval;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b1;
    logic       cfg_we    = 1'b0;
    logic [6:0] in_x      = '0;
    logic [2:0] cfg_addr  = '0;
    logic [14:0] cfg_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic       out_data;
    logic       cfg_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    maj_net_eval dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // operand = {inv, sel}; sel 0 = const0, 1..7 = x0..x6, 8..13 = n0..n5
    function automatic logic [4:0] op(input logic inv, input int sel);
        return {inv, 4'(sel)};
    endfunction

    function automatic logic [14:0] nd(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] c);
        return {c, b, a};
    endfunction

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Reference for the test-1 network, written directly from its equations.
    function automatic logic ref_model(input logic [6:0] x);
        logic n0, n1, n2, n3, n4, n5;
        n0 = maj(x[2], x[3], x[4]);
        n1 = maj(x[0], x[2], x[4]);
        n2 = maj(x[1], x[2], x[3]);
        n3 = maj(x[5], x[6], n0);
        n4 = maj(x[0], x[1], n3);
        n5 = maj(n1, n2, n4);
        return n5;
    endfunction

    // Driver tasks: all enter and leave on a falling edge.
    task automatic cfg_write(input logic [2:0] addr, input logic [14:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic load_table1();
        cfg_write(3'd0, nd(op(0, 3), op(0, 4), op(0, 5)));
        cfg_write(3'd1, nd(op(0, 1), op(0, 3), op(0, 5)));
        cfg_write(3'd2, nd(op(0, 2), op(0, 3), op(0, 4)));
        cfg_write(3'd3, nd(op(0, 6), op(0, 7), op(0, 8)));
        cfg_write(3'd4, nd(op(0, 1), op(0, 2), op(0, 11)));
        cfg_write(3'd5, nd(op(0, 9), op(0, 10), op(0, 12)));
        cfg_write(3'd6, {10'd0, op(0, 13)});
    endtask

    // Wait (bounded) for out_valid; lat counts rising edges since the accept.
    task automatic wait_valid(inout int lat);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Send one vector with out_ready=1; returns result and latency.
    task automatic run_vector(input logic [6:0] x, output logic res, output int lat);
        in_valid = 1'b1;
        in_x     = x;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        wait_valid(lat);
        res = out_data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic res;
        int   lat;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_data  !== 1'b0) begin n_fail++; $display("FAIL reset_out_data: got %b want 0", out_data); end
        n_tests++; if (cfg_err   !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
        n_tests++; if (busy      !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (in_ready  !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        run_vector(7'h7F, res, lat);
        n_tests++; if (res !== 1'b0) begin n_fail++; $display("FAIL reset_zero_table: got %b want 0", res); end
        n_tests++; if (lat != 6) begin n_fail++; $display("FAIL reset_latency: got %0d want 6", lat); end
    endtask

    task automatic test_table();
        logic res;
        int   lat;
        load_table1();
        run_vector(7'b0000011, res, lat);
        n_tests++; if (res !== 1'b0) begin n_fail++; $display("FAIL table_x03: got %b want 0", res); end
        n_tests++; if (lat != 6) begin n_fail++; $display("FAIL table_x03_latency: got %0d want 6", lat); end
        run_vector(7'b0001111, res, lat);
        n_tests++; if (res !== 1'b1) begin n_fail++; $display("FAIL table_x0f: got %b want 1", res); end
        n_tests++; if (lat != 6) begin n_fail++; $display("FAIL table_x0f_latency: got %0d want 6", lat); end
    endtask

    task automatic test_back_to_back();
        logic res;
        int   lat;
        for (int v = 0; v < 128; v++) begin
            run_vector(7'(v), res, lat);
            n_tests++;
            if (res !== ref_model(7'(v))) begin
                n_fail++;
                $display("FAIL all_vectors x=%02h: got %b want %b", v, res, ref_model(7'(v)));
            end
            n_tests++;
            if (lat != 6) begin
                n_fail++;
                $display("FAIL all_vectors_latency x=%02h: got %0d want 6", v, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 7'b0001111;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        wait_valid(lat);
        // Offer the next vector while the result is stalled.
        in_valid = 1'b1;
        in_x     = 7'b0000011;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d: got %b want 1", c, out_valid); end
            n_tests++; if (out_data  !== 1'b1) begin n_fail++; $display("FAIL bp_data c%0d: got %b want 1", c, out_data); end
            n_tests++; if (in_ready  !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        n_tests++; if (in_ready  !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept: busy got %b want 1", busy); end
        lat = 0;
        wait_valid(lat);
        n_tests++; if (out_data !== 1'b0) begin n_fail++; $display("FAIL bp_next_result: got %b want 0", out_data); end
        n_tests++; if (lat != 6) begin n_fail++; $display("FAIL bp_next_latency: got %0d want 6", lat); end
        @(negedge clk);
    endtask

    task automatic test_cfg_err();
        logic res;
        int   lat;
        in_valid = 1'b1;
        in_x     = 7'b0001111;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        // Attempt to zero node 0 while evaluating.
        cfg_write(3'd0, 15'd0);
        n_tests++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_eval_pulse: got %b want 1", cfg_err); end
        @(negedge clk);
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_eval_single: got %b want 0", cfg_err); end
        lat = 3;
        wait_valid(lat);
        n_tests++; if (out_data !== 1'b1) begin n_fail++; $display("FAIL err_eval_result: got %b want 1", out_data); end
        @(negedge clk);
        cfg_write(3'd7, 15'd0);
        n_tests++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_addr_pulse: got %b want 1", cfg_err); end
        @(negedge clk);
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_addr_single: got %b want 0", cfg_err); end
        // A legal write (same output select) raises no error.
        cfg_write(3'd6, {10'd0, op(0, 13)});
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_legal_write: got %b want 0", cfg_err); end
        run_vector(7'b0001111, res, lat);
        n_tests++; if (res !== 1'b1) begin n_fail++; $display("FAIL err_readback_x0f: got %b want 1", res); end
        run_vector(7'b0000011, res, lat);
        n_tests++; if (res !== 1'b0) begin n_fail++; $display("FAIL err_readback_x03: got %b want 0", res); end
    endtask

    task automatic test_same_edge_cfg();
        logic res;
        int   lat;
        // Output switched to x0 on the accepting edge; old output (n5) gives 0.
        cfg_we   = 1'b1;
        cfg_addr = 3'd6;
        cfg_data = {10'd0, op(0, 1)};
        in_valid = 1'b1;
        in_x     = 7'b0000001;
        @(negedge clk);
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL same_edge_err: got %b want 0", cfg_err); end
        lat = 0;
        wait_valid(lat);
        n_tests++; if (out_data !== 1'b1) begin n_fail++; $display("FAIL same_edge_result: got %b want 1", out_data); end
        @(negedge clk);
        // Select code 14 is past the last node and reads 0.
        cfg_write(3'd6, {10'd0, op(0, 14)});
        run_vector(7'h7F, res, lat);
        n_tests++; if (res !== 1'b0) begin n_fail++; $display("FAIL sel_out_of_range: got %b want 0", res); end
        // Self reference on node 0 reads 0: MAJ(n0, x0, x1) with x0=1, x1=0 -> 0.
        cfg_write(3'd0, nd(op(0, 8), op(0, 1), op(0, 2)));
        cfg_write(3'd6, {10'd0, op(0, 8)});
        run_vector(7'b0000001, res, lat);
        n_tests++; if (res !== 1'b0) begin n_fail++; $display("FAIL self_ref: got %b want 0", res); end
    endtask

    task automatic test_inv();
        logic res;
        int   lat;
        logic exp_inv;
`ifdef MAJ_INV_EN
        exp_inv = 1'b1;
`else
        exp_inv = 1'b0;
`endif
        cfg_write(3'd0, nd(op(1, 0), op(1, 0), op(0, 1)));
        cfg_write(3'd6, {10'd0, op(0, 8)});
        run_vector(7'b0000000, res, lat);
        n_tests++; if (res !== exp_inv) begin n_fail++; $display("FAIL inv_node: got %b want %b", res, exp_inv); end
        cfg_write(3'd6, {10'd0, op(1, 0)});
        run_vector(7'b0000000, res, lat);
        n_tests++; if (res !== exp_inv) begin n_fail++; $display("FAIL inv_out: got %b want %b", res, exp_inv); end
    endtask

    task automatic test_reset_mid_eval();
        logic res;
        int   lat;
        int   seen;
        load_table1();
        in_valid = 1'b1;
        in_x     = 7'h7F;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy      !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_no_result: got %0d valid cycles want 0", seen); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        // Table 1 would give 1 here; the cleared table gives 0.
        run_vector(7'h7F, res, lat);
        n_tests++; if (res !== 1'b0) begin n_fail++; $display("FAIL rst_mid_fresh: got %b want 0", res); end
        n_tests++; if (lat != 6) begin n_fail++; $display("FAIL rst_mid_latency: got %0d want 6", lat); end
    endtask

    initial begin
        test_reset();
        test_table();
        test_back_to_back();
        test_backpressure();
        test_cfg_err();
        test_same_edge_cfg();
        test_inv();
        test_reset_mid_eval();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
